// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM driving datapath enables,
// mux selects and the ULA operation for lw/sw/R/I/beq/jal.
module unidade_controle_multiciclo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ULAControl,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state;
    state_t     next;
    state_t     st_eff;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= next;
    end

    // Next-state logic; op is only consulted in DECODE and MEMADR.
    always_comb begin
        next = FETCH;
        unique case (state)
            FETCH:    next = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) next = MEMADR;
                else if (op == OP_R)            next = EXECUTER;
                else if (op == OP_I)            next = EXECUTEI;
                else if (op == OP_BEQ)          next = BEQ;
                else if (op == OP_JAL)          next = JAL;
                else                            next = FETCH;
            end
            MEMADR:   next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next = MEMWB;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            JAL:      next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    // While in reset the outputs present FETCH values with writes masked.
    assign st_eff = rst_n ? state : FETCH;

    // Moore outputs per state, everything defaulting to zero.
    always_comb begin
        ir_write_raw  = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        unique case (st_eff)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_update    = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB:    reg_write_raw = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = rst_n & (pc_update | (branch & Zero));
    assign IRWrite  = rst_n & ir_write_raw;
    assign MemWrite = rst_n & mem_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign estado   = st_eff;

    // ULA operation decode from ALUOp and the instruction fields.
    always_comb begin
        ULAControl = 3'b000;
        unique case (alu_op)
            2'b01: ULAControl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  ULAControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ULAControl = 3'b101;
                    3'b110:  ULAControl = 3'b011;
                    3'b111:  ULAControl = 3'b010;
                    default: ULAControl = 3'b000;
                endcase
            end
            default: ULAControl = 3'b000;
        endcase
    end

    // Immediate format select, decoded from op in every state.
    always_comb begin
        ImmSrc = 2'b00;
        unique case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for the multicycle control unit, comparing every
// cycle against an instruction-level reference model.
module tb_unidade_controle_multiciclo;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ULAControl;
    logic [3:0] estado;

    logic [21:0] obs_v;
    logic [21:0] exp_v;
    int total = 0;
    int bad = 0;

    unidade_controle_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ULAControl(ULAControl),
        .estado(estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // States visited by one instruction, starting at FETCH.
    function automatic void build(input logic [6:0] o, output int s[5], output int n);
        s = '{0, 1, 0, 0, 0};
        case (o)
            LW: begin s[2] = 2; s[3] = 3; s[4] = 4; n = 5; end
            SW: begin s[2] = 2; s[3] = 5; n = 4; end
            RT: begin s[2] = 6; s[3] = 8; n = 4; end
            IT: begin s[2] = 7; s[3] = 8; n = 4; end
            BQ: begin s[2] = 9; n = 3; end
            JL: begin s[2] = 10; s[3] = 8; n = 4; end
            default: n = 2;
        endcase
    endfunction

    // Expected outputs {estado,PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,
    // ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ULAControl}.
    function automatic logic [21:0] model(input int st_in, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic rn);
        int st;
        logic pcu, br, irw, adr, mw, rw, pcw;
        logic [1:0] rs, asa, asb, aop, imm;
        logic [2:0] ula;
        st  = rn ? st_in : 0;
        irw = (st == 0);
        pcu = (st == 0) || (st == 10);
        br  = (st == 9);
        adr = (st == 3) || (st == 5);
        mw  = (st == 5);
        rw  = (st == 4) || (st == 8);
        rs  = (st == 0) ? 2'd2 : (st == 4) ? 2'd1 : 2'd0;
        asa = (st == 1 || st == 10) ? 2'd1 :
              (st == 2 || st == 6 || st == 7 || st == 9) ? 2'd2 : 2'd0;
        asb = (st == 0 || st == 10) ? 2'd2 :
              (st == 1 || st == 2 || st == 7) ? 2'd1 : 2'd0;
        aop = (st == 6 || st == 7) ? 2'd2 : (st == 9) ? 2'd1 : 2'd0;
        ula = 3'd0;
        if (aop == 2'd1) ula = 3'd1;
        else if (aop == 2'd2) begin
            if (f3 == 3'd0)      ula = (o[5] && f7) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) ula = 3'd5;
            else if (f3 == 3'd6) ula = 3'd3;
            else if (f3 == 3'd7) ula = 3'd2;
        end
        imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        pcw = pcu || (br && z);
        if (!rn) begin
            pcw = 0; irw = 0; mw = 0; rw = 0;
        end
        return {4'(st), pcw, adr, mw, irw, rw, rs, asa, asb, imm, ula};
    endfunction

    // Apply inputs for one cycle, then sample DUT and model.
    task automatic drive_step(input int st, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input logic z, input logic rn);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; rst_n = rn;
        #1;
        obs_v = {estado, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ULAControl};
        exp_v = model(st, o, f3, f7, z, rn);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_step(0, LW, 3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset%0d got=%h want=%h", i, obs_v, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_lw();
        int s[5];
        int n;
        build(LW, s, n);
        for (int i = 0; i < n; i++) begin
            drive_step(s[i], LW, 3'b010, 1'b0, 1'($urandom), 1'b1);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL lw step%0d got=%h want=%h", i, obs_v, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_sub();
        int s[5];
        int n;
        build(RT, s, n);
        for (int i = 0; i < n; i++) begin
            drive_step(s[i], RT, 3'b000, 1'b1, 1'($urandom), 1'b1);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL sub step%0d got=%h want=%h", i, obs_v, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_beq();
        int s[5];
        int n;
        logic z;
        build(BQ, s, n);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < n; i++) begin
                z = (s[i] == 9) ? (r == 0) : 1'($urandom);
                drive_step(s[i], BQ, 3'b000, 1'b0, z, 1'b1);
                total++;
                if (obs_v !== exp_v) begin
                    bad++;
                    $display("FAIL beq z%0d step%0d got=%h want=%h", r == 0, i, obs_v, exp_v);
                end
                adv();
            end
        end
    endtask

    task automatic test_sw();
        int s[5];
        int n;
        build(SW, s, n);
        for (int i = 0; i < n; i++) begin
            drive_step(s[i], SW, 3'b010, 1'b0, 1'($urandom), 1'b1);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL sw step%0d got=%h want=%h", i, obs_v, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_illegal();
        int s[5];
        int n;
        build(BAD, s, n);
        for (int i = 0; i < n; i++) begin
            drive_step(s[i], BAD, 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL illegal step%0d got=%h want=%h", i, obs_v, exp_v);
            end
            adv();
        end
        drive_step(0, BAD, 3'd0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL illegal_return got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        int st[11] = '{0, 1, 2, 3, 3, 0, 0, 1, 2, 3, 4};
        bit rn[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 11; i++) begin
            drive_step(st[i], LW, 3'b010, 1'b0, 1'($urandom), rn[i]);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset_mid step%0d got=%h want=%h", i, obs_v, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_random();
        logic [6:0] legal[6] = '{LW, SW, RT, IT, BQ, JL};
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;
        int s[5];
        int n;
        for (int k = 0; k < 60; k++) begin
            o  = ($urandom_range(4, 0) == 0) ? 7'($urandom) : legal[$urandom_range(5, 0)];
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            build(o, s, n);
            for (int i = 0; i < n; i++) begin
                if (s[i] == 1 || s[i] == 2)
                    drive_step(s[i], o, f3, f7, 1'($urandom), 1'b1);
                else if (s[i] == 6 || s[i] == 7)
                    drive_step(s[i], 7'($urandom), f3, f7, 1'($urandom), 1'b1);
                else
                    drive_step(s[i], 7'($urandom), 3'($urandom), 1'($urandom),
                               1'($urandom), 1'b1);
                total++;
                if (obs_v !== exp_v) begin
                    bad++;
                    $display("FAIL rand k%0d op%b step%0d got=%h want=%h",
                             k, o, i, obs_v, exp_v);
                end
                adv();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_sub();
        test_beq();
        test_sw();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
